seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexing scan controller that sits directly upstream of the Nexys A7-100T seven-segment decoder. It holds a 32-bit value as eight hex nibbles and steps through digits 0..7 at a fixed refresh rate, driving the decoder's `num` and `sel` inputs. It also provides tear-free value updates, so a new value is committed only at a frame boundary.

## Interface
- `TICK_DIV`, default 100_000: clock cycles per digit slot; 1 kHz digit rate and 125 Hz frame rate at 100 MHz; legal range is ≥ 2.
- `clk`  input  1  system clock; everything is rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `value_i`  input  32  display value; nibble k (bits 4k+3:4k) is shown on digit k.
- `load_i`  input  1  one-cycle strobe that captures `value_i` into the pending register.
- `num_o`  output  4  nibble for the current digit; connects to the decoder's `num`.
- `sel_o`  output  3  current digit index; connects to the decoder's `sel`.
- `blank_o`  output  1  current digit is to be blanked; top level forces the anodes high.
- `pending_o`  output  1  a loaded value is waiting for commit.
- `frame_o`  output  1  one-cycle pulse on each frame boundary.

## Operation
- Prescaler `cnt` counts from 0 to TICK_DIV-1 and wraps to 0.
  - Its width is $clog2(TICK_DIV).
  - `tick` = (cnt == TICK_DIV-1).
- Digit stepping on `tick`:
  - `sel_o` increments modulo 8.
  - When `sel_o` == 7, the tick is a frame boundary: `sel_o` goes to 0 and `frame_o` is high for that same clock edge's following cycle.
- Registers: `active` (32 bits, the value being shown) and `pend` (32 bits) with flag `pend_v`. `pending_o` = `pend_v`.
- `load_i` = 1 outside a boundary:
  - `pend` ← `value_i`, `pend_v` ← 1.
  - Loading while `pend_v` is already 1 overwrites `pend`; the last load wins.
- Boundary with `pend_v` = 1 and `load_i` = 0: `active` ← `pend`, `pend_v` ← 0.
- Boundary with `pend_v` = 1 and `load_i` = 1:
  - `active` ← old `pend`.
  - `pend` ← `value_i`, and `pend_v` stays 1.
- Boundary with `pend_v` = 0 and `load_i` = 1:
  - `pend` ← `value_i`, `pend_v` ← 1.
  - Commit happens at the next boundary, not this one.
- Boundary with `pend_v` = 0 and `load_i` = 0: `active` is unchanged.
- `num_o` = `active`[4·`sel_o`+3 : 4·`sel_o`]. It is combinational from registers, so `num_o` and `sel_o` always change on the same edge.

## Timing
- Reset values while `rst` = 1 and immediately after release:
  - `cnt` = 0, `sel_o` = 0.
  - `active` = 0, `pend` = 0, `pend_v` = 0.
  - `num_o` = 0, `blank_o` = 0, `pending_o` = 0, `frame_o` = 0.
- Reset asserted mid-frame or mid-pending: all state clears asynchronously and any pending value is discarded.
- After reset release, `sel_o` stays at 0 for exactly TICK_DIV cycles, then steps every TICK_DIV cycles.
- Frame period is 8·TICK_DIV cycles.
- Load-to-display latency:
  - Minimum: 1 cycle, when the load lands on the last cycle before a boundary (`sel_o` = 7, `cnt` = TICK_DIV-2).
  - Maximum: 8·TICK_DIV cycles.
- `value_i` is sampled only in cycles where `load_i` = 1.

## Configuration
- Macro: `SEG_SCAN_LEADING_ZERO_BLANK_EN`.
- Defined:
  - `blank_o` = 1 when `sel_o` ≥ 1 and every nibble of `active` from index `sel_o` through 7 is zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - `blank_o` is combinational from `active` and `sel_o`.
- Undefined: `blank_o` is tied to 0 and all eight digits are always shown.

## Test plan
All scenarios use TICK_DIV = 4.
1. Reset: hold `rst` for 3 cycles, then release -> all outputs are 0 and `sel_o` steps 0→1 after exactly 4 cycles.
2. Scan order: free-run for 32 cycles -> `sel_o` runs 0..7, each held 4 cycles, and `frame_o` pulses exactly once at the 7→0 step.
3. Tear-free commit: load 32'h89AB_CDEF while `sel_o` = 3 -> `pending_o` = 1 and `num_o` keeps showing the old value until `sel_o` wraps to 0; then digits 0..7 read F, E, D, C, B, A, 9, 8 and `pending_o` = 0.
4. Simultaneous load and boundary: pend = 32'h1111_1111, then load 32'h2222_2222 in the boundary cycle -> `active` = 32'h1111_1111, `pending_o` stays 1, and 32'h2222_2222 is shown after the next frame.
5. Leading-zero blanking (macro defined): load 32'h0000_00A5 -> `blank_o` = 0 on digits 0–1 and `blank_o` = 1 on digits 2–7. Repeat with the macro undefined -> `blank_o` = 0 on all digits.
6. Reset mid-pending: load 32'hFFFF_FFFF, then assert `rst` before the boundary -> after release, `active` = 0, `pending_o` = 0, and `num_o` = 0 on all digits.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: steps digits 0..7 and commits new values only at frame boundaries.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl #(
  parameter int TICK_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_i,
  input  logic        load_i,
  output logic [3:0]  num_o,
  output logic [2:0]  sel_o,
  output logic        blank_o,
  output logic        pending_o,
  output logic        frame_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [31:0]   active;
  logic [31:0]   pend;
  logic          pend_v;
  logic          tick;
  logic          boundary;

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (sel_o == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      sel_o   <= 3'd0;
      frame_o <= 1'b0;
      active  <= 32'h0;
      pend    <= 32'h0;
      pend_v  <= 1'b0;
    end else begin
      frame_o <= boundary;
      if (tick) begin
        cnt   <= '0;
        sel_o <= sel_o + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // A boundary commits the old pending value even when a new load lands in the same cycle.
      if (boundary && pend_v) begin
        active <= pend;
      end
      if (load_i) begin
        pend   <= value_i;
        pend_v <= 1'b1;
      end else if (boundary) begin
        pend_v <= 1'b0;
      end
    end
  end

  assign pending_o = pend_v;
  assign num_o     = active[{sel_o, 2'b00} +: 4];

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic [31:0] upper;
  assign upper   = active >> {sel_o, 2'b00};
  assign blank_o = (sel_o != 3'd0) && (upper == 32'h0);
`else
  assign blank_o = 1'b0;
`endif

endmodule
